// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus bundle for apb_master.
// The master modport is the initiator's view. The slave modport is the view of the command source and the APB target.
interface apb_master_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
  logic [AMBA_WORD-1:0]       cmd_wdata;

  logic                       rsp_valid;
  logic [AMBA_WORD-1:0]       rsp_rdata;
  logic                       rsp_err;

  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PWRITE;
  logic                       PSEL;
  logic                       PENABLE;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: runs one valid/ready command at a time as a SETUP/ACCESS transfer.
// Each accepted command produces a one-cycle response pulse, with an optional ACCESS timeout.
module apb_master #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic          clk,
  input logic          rst,
  apb_master_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]                 state_q,     state_d;
  logic [CNT_W-1:0]           cnt_q,       cnt_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q,    pwdata_d;
  logic                       pwrite_q,    pwrite_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_err_q,   rsp_err_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pwrite_d = bus.cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so that a completion on the last allowed cycle beats the timeout.
        if (bus.PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: dut_a uses TIMEOUT_CYCLES=4 and dut_b uses TIMEOUT_CYCLES=2.
// Expected responses are queued at command issue and compared whenever a DUT raises rsp_valid.
module tb_apb_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  rsp_t qa[$];
  rsp_t qb[$];

  always #5 clk = ~clk;

  apb_master_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) ifa ();
  apb_master_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) ifb ();

  apb_master #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .TIMEOUT_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  apb_master #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .TIMEOUT_CYCLES(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    return r;
  endfunction

  // Advance to the next falling edge, then score any response pulse from either DUT.
  task automatic tick();
    rsp_t e;
    @(negedge clk);
    if (ifa.rsp_valid === 1'b1) begin
      check("a_rsp_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_rsp_rdata", ifa.rsp_rdata, e.rdata);
        check("a_rsp_err", 32'(ifa.rsp_err), 32'(e.err));
      end
    end else begin
      check("a_rsp_quiet", ifa.rsp_rdata | 32'(ifa.rsp_err), 0);
    end
    if (ifb.rsp_valid === 1'b1) begin
      check("b_rsp_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_rsp_rdata", ifb.rsp_rdata, e.rdata);
        check("b_rsp_err", 32'(ifb.rsp_err), 32'(e.err));
      end
    end else begin
      check("b_rsp_quiet", ifb.rsp_rdata | 32'(ifb.rsp_err), 0);
    end
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_addr = '0; ifa.cmd_wdata = '0;
    ifa.PRDATA    = '0;   ifa.PREADY    = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_addr = '0; ifb.cmd_wdata = '0;
    ifb.PRDATA    = '0;   ifb.PREADY    = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_psel",      32'(ifa.PSEL), 0);
    check("rst_penable",   32'(ifa.PENABLE), 0);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 0);
    check("rst_paddr",     32'(ifa.PADDR), 0);
    check("rst_pwdata",    ifa.PWDATA, 0);
    check("rst_pwrite",    32'(ifa.PWRITE), 0);
    check("rst_b_psel",    32'(ifb.PSEL), 0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(ifa.cmd_ready), 1);
    check("rst_b_cmd_ready", 32'(ifb.cmd_ready), 1);

    // 1: write with zero wait states
    ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b1;
    ifa.cmd_addr  = 20'h00004; ifa.cmd_wdata = 32'hDEADBEEF; ifa.PREADY = 1'b1;
    qa.push_back(mk(32'h0, 1'b0));
    tick();
    ifa.cmd_valid = 1'b0;
    check("t1_setup_psel",    32'(ifa.PSEL), 1);
    check("t1_setup_penable", 32'(ifa.PENABLE), 0);
    check("t1_setup_ready",   32'(ifa.cmd_ready), 0);
    check("t1_setup_paddr",   32'(ifa.PADDR), 32'h4);
    check("t1_setup_pwrite",  32'(ifa.PWRITE), 1);
    check("t1_setup_pwdata",  ifa.PWDATA, 32'hDEADBEEF);
    tick();
    check("t1_access_psel",    32'(ifa.PSEL), 1);
    check("t1_access_penable", 32'(ifa.PENABLE), 1);
    check("t1_access_paddr",   32'(ifa.PADDR), 32'h4);
    check("t1_access_pwdata",  ifa.PWDATA, 32'hDEADBEEF);
    tick();
    check("t1_rsp_valid", 32'(ifa.rsp_valid), 1);
    check("t1_idle_psel", 32'(ifa.PSEL), 0);

    // 2: read with three wait states; PRDATA is junk until the completing cycle
    ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b0; ifa.cmd_addr = 20'h00010;
    ifa.cmd_wdata = 32'h0000_0077; ifa.PREADY = 1'b0; ifa.PRDATA = 32'hBAD0BAD0;
    qa.push_back(mk(32'h12345678, 1'b0));
    tick();
    ifa.cmd_valid = 1'b0;
    check("t2_setup_ready", 32'(ifa.cmd_ready), 0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      check("t2_penable", 32'(ifa.PENABLE), 1);
      check("t2_psel",    32'(ifa.PSEL), 1);
      check("t2_paddr",   32'(ifa.PADDR), 32'h10);
      check("t2_pwrite",  32'(ifa.PWRITE), 0);
      check("t2_ready",   32'(ifa.cmd_ready), 0);
      if (k == 4) begin
        ifa.PREADY = 1'b1; ifa.PRDATA = 32'h12345678;
      end
      tick();
    end
    check("t2_rsp_valid", 32'(ifa.rsp_valid), 1);
    check("t2_penable_low", 32'(ifa.PENABLE), 0);

    // 3: timeout after exactly four ACCESS cycles
    ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b0; ifa.cmd_addr = 20'h00020;
    ifa.PREADY = 1'b0; ifa.PRDATA = 32'hFFFF0000;
    qa.push_back(mk(32'h0, 1'b1));
    tick();
    ifa.cmd_valid = 1'b0;
    tick();
    n = 0;
    while (ifa.PENABLE === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    check("t3_access_cycles", 32'(n), 4);
    check("t3_psel_low",      32'(ifa.PSEL), 0);
    check("t3_rsp_valid",     32'(ifa.rsp_valid), 1);
    check("t3_ready",         32'(ifa.cmd_ready), 1);
    tick();
    check("t3_ready_next",    32'(ifa.cmd_ready), 1);
    check("t3_rsp_pulse",     32'(ifa.rsp_valid), 0);

    // 4: back-to-back commands with cmd_valid held high
    ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b1; ifa.cmd_addr = 20'h00000;
    ifa.cmd_wdata = 32'h1; ifa.PREADY = 1'b1; ifa.PRDATA = 32'hCAFE0008;
    qa.push_back(mk(32'h0, 1'b0));
    tick();
    ifa.cmd_write = 1'b0; ifa.cmd_addr = 20'h00008; ifa.cmd_wdata = 32'h0;
    qa.push_back(mk(32'hCAFE0008, 1'b0));
    tick();
    check("t4_a1_paddr",  32'(ifa.PADDR), 0);
    check("t4_a1_pwrite", 32'(ifa.PWRITE), 1);
    check("t4_a1_pwdata", ifa.PWDATA, 32'h1);
    tick();
    check("t4_gap_ready", 32'(ifa.cmd_ready), 1);
    check("t4_gap_psel",  32'(ifa.PSEL), 0);
    check("t4_rsp1",      32'(ifa.rsp_valid), 1);
    tick();
    ifa.cmd_valid = 1'b0;
    check("t4_s2_psel",    32'(ifa.PSEL), 1);
    check("t4_s2_penable", 32'(ifa.PENABLE), 0);
    check("t4_s2_paddr",   32'(ifa.PADDR), 32'h8);
    check("t4_s2_pwrite",  32'(ifa.PWRITE), 0);
    tick();
    tick();
    check("t4_rsp2", 32'(ifa.rsp_valid), 1);

    // 5: reset during a stalled ACCESS drops the transfer without a response
    ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b0; ifa.cmd_addr = 20'h00030;
    ifa.cmd_wdata = 32'h55; ifa.PREADY = 1'b0;
    tick();
    ifa.cmd_valid = 1'b0;
    tick();
    check("t5_in_access", 32'(ifa.PENABLE), 1);
    rst = 1'b1;
    tick();
    check("t5_psel",      32'(ifa.PSEL), 0);
    check("t5_penable",   32'(ifa.PENABLE), 0);
    check("t5_paddr",     32'(ifa.PADDR), 0);
    check("t5_pwdata",    ifa.PWDATA, 0);
    check("t5_no_rsp",    32'(ifa.rsp_valid), 0);
    rst = 1'b0;
    tick();
    check("t5_no_rsp2",   32'(ifa.rsp_valid), 0);
    check("t5_ready",     32'(ifa.cmd_ready), 1);
    ifa.cmd_valid = 1'b1; ifa.cmd_addr = 20'h00044;
    ifa.PREADY = 1'b1; ifa.PRDATA = 32'h0BADF00D;
    qa.push_back(mk(32'h0BADF00D, 1'b0));
    tick();
    ifa.cmd_valid = 1'b0;
    tick();
    tick();
    check("t5_rsp_valid", 32'(ifa.rsp_valid), 1);

    // 6: PREADY on the final timeout cycle completes normally (dut_b)
    ifb.cmd_valid = 1'b1; ifb.cmd_write = 1'b0; ifb.cmd_addr = 20'h00050;
    ifb.PREADY = 1'b0; ifb.PRDATA = 32'h0;
    qb.push_back(mk(32'hA5A5A5A5, 1'b0));
    tick();
    ifb.cmd_valid = 1'b0;
    tick();
    check("t6_access1", 32'(ifb.PENABLE), 1);
    tick();
    check("t6_access2", 32'(ifb.PENABLE), 1);
    ifb.PREADY = 1'b1; ifb.PRDATA = 32'hA5A5A5A5;
    tick();
    check("t6_rsp_valid", 32'(ifb.rsp_valid), 1);
    check("t6_psel_low",  32'(ifb.PSEL), 0);
    ifb.PREADY = 1'b0;

    repeat (3) tick();
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_queue_drained", 32'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
